// File: rtl/seq_ctrl_pkg.sv
// Shared definitions for the fixed-sequence step counter and its controller:
// FSM state encoding, the six legal counter values and the next-value function.
package seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [2:0] SEQ0 = 3'b000;
    localparam logic [2:0] SEQ1 = 3'b001;
    localparam logic [2:0] SEQ2 = 3'b011;
    localparam logic [2:0] SEQ3 = 3'b101;
    localparam logic [2:0] SEQ4 = 3'b111;
    localparam logic [2:0] SEQ5 = 3'b010;

    // Off-sequence values (100, 110) recover to the start of the sequence.
    function automatic logic [2:0] seq_next(input logic [2:0] cur);
        case (cur)
            SEQ0:    return SEQ1;
            SEQ1:    return SEQ2;
            SEQ2:    return SEQ3;
            SEQ3:    return SEQ4;
            SEQ4:    return SEQ5;
            SEQ5:    return SEQ0;
            default: return SEQ0;
        endcase
    endfunction

endpackage

// File: rtl/seq_counter_ctrl_if.sv
// Request/status bundle between the lab front panel and the sequencing controller.
interface seq_counter_ctrl_if #(
    parameter int STEP_W = 4,
    parameter int LAP_W  = 4
);
    logic              start;
    logic [STEP_W-1:0] num_steps;
    logic              continuous;
    logic              pause;
    logic              abort;
    logic [2:0]        count;
    logic              step_en;
    logic              busy;
    logic              done;
    logic              aborted;
    logic [LAP_W-1:0]  lap_cnt;

    modport master (
        output start, num_steps, continuous, pause, abort,
        input  count, step_en, busy, done, aborted, lap_cnt
    );

    modport slave (
        input  start, num_steps, continuous, pause, abort,
        output count, step_en, busy, done, aborted, lap_cnt
    );
endinterface

// File: rtl/seq_step_counter.sv
// 3-bit counter that walks 000,001,011,101,111,010 on each enabled edge.
// clear wins over enable; wrap flags an enabled step out of 010.
module seq_step_counter
    import seq_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       clear,
    output logic [2:0] count,
    output logic       wrap
);

    logic [2:0] count_q;
    logic [2:0] count_d;

    // Next counter value: clear, advance, or hold.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = SEQ0;
        end else if (enable) begin
            count_d = seq_next(count_q);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= SEQ0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign wrap  = enable & (count_q == SEQ5);

endmodule

// File: rtl/seq_counter_ctrl.sv
// Sequencing controller: runs the step counter for a requested number of
// enabled cycles (or continuously) with pause/abort, and reports status.
module seq_counter_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int STEP_W = 4,
    parameter int LAP_W  = 4
) (
    input  logic               clk,
    input  logic               reset,
    seq_counter_ctrl_if.slave  bus
);

    localparam logic [LAP_W-1:0] LAP_MAX = '1;

    state_t            state_q,      state_d;
    logic [STEP_W-1:0] steps_left_q, steps_left_d;
    logic              mode_q,       mode_d;
    logic [LAP_W-1:0]  lap_q,        lap_d;
    logic              aborted_q,    aborted_d;
    logic              step_en;
    logic              cnt_clear;
    logic              wrap;
    logic [2:0]        count;

    seq_step_counter u_counter (
        .clk    (clk),
        .reset  (reset),
        .enable (step_en),
        .clear  (cnt_clear),
        .count  (count),
        .wrap   (wrap)
    );

    // Next-state, counter control and run bookkeeping.
    always_comb begin
        state_d      = state_q;
        steps_left_d = steps_left_q;
        mode_d       = mode_q;
        lap_d        = lap_q;
        aborted_d    = 1'b0;
        cnt_clear    = 1'b0;
        step_en      = (state_q == ST_RUN) & ~bus.abort & ~bus.pause;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    cnt_clear    = 1'b1;
                    lap_d        = '0;
                    steps_left_d = bus.num_steps;
                    mode_d       = bus.continuous;
                    // A zero-length one-shot completes without ever advancing.
                    if (!bus.continuous && (bus.num_steps == '0)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (bus.abort) begin
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                end else if (bus.pause) begin
                    state_d = ST_PAUSED;
                end else if (!mode_q) begin
                    steps_left_d = steps_left_q - STEP_W'(1);
                    if (steps_left_q == STEP_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_PAUSED: begin
                if (bus.abort) begin
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                end else if (!bus.pause) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Wraps only occur in RUN, so this never collides with the start-time clear.
        if (wrap && (lap_q != LAP_MAX)) begin
            lap_d = lap_q + LAP_W'(1);
        end
    end

    // Controller state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            steps_left_q <= '0;
            mode_q       <= 1'b0;
            lap_q        <= '0;
            aborted_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            steps_left_q <= steps_left_d;
            mode_q       <= mode_d;
            lap_q        <= lap_d;
            aborted_q    <= aborted_d;
        end
    end

    assign bus.count   = count;
    assign bus.step_en = step_en;
    assign bus.busy    = (state_q == ST_RUN) || (state_q == ST_PAUSED);
    assign bus.done    = (state_q == ST_DONE);
    assign bus.aborted = aborted_q;
    assign bus.lap_cnt = lap_q;

endmodule

// File: tb/tb_seq_counter_ctrl.sv
// Bench for seq_counter_ctrl: directed scenarios with literal expectations,
// then randomized stimulus, all compared every cycle against a position/lap model.
module tb_seq_counter_ctrl;

    localparam int STEP_W  = 4;
    localparam int LAP_W   = 4;
    localparam int LAP_MAX = (1 << LAP_W) - 1;

    // Model phases: 0 idle, 1 running, 2 paused, 3 done.
    localparam int P_IDLE = 0, P_RUN = 1, P_PAUSE = 2, P_DONE = 3;

    logic clk = 1'b0;
    logic reset;

    seq_counter_ctrl_if #(.STEP_W(STEP_W), .LAP_W(LAP_W)) bus ();

    seq_counter_ctrl #(.STEP_W(STEP_W), .LAP_W(LAP_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    logic [2:0] seq_tab [6] = '{3'b000, 3'b001, 3'b011, 3'b101, 3'b111, 3'b010};

    int m_phase = P_IDLE;
    int m_pos   = 0;
    int m_laps  = 0;
    int m_rem   = 0;
    bit m_cont  = 1'b0;
    bit m_abt   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: position in the 6-entry sequence, laps, remaining steps.
    always @(posedge clk) begin : model
        int ph, pos, laps, rem;
        bit cont, abt;
        ph   = m_phase;
        pos  = m_pos;
        laps = m_laps;
        rem  = m_rem;
        cont = m_cont;
        abt  = 1'b0;
        if (reset) begin
            ph = P_IDLE; pos = 0; laps = 0; rem = 0; cont = 1'b0;
        end else begin
            case (ph)
                P_IDLE: if (bus.start) begin
                    pos  = 0;
                    laps = 0;
                    rem  = int'(bus.num_steps);
                    cont = bus.continuous;
                    ph   = (!cont && rem == 0) ? P_DONE : P_RUN;
                end
                P_RUN: begin
                    if (bus.abort) begin
                        ph = P_IDLE; abt = 1'b1;
                    end else if (bus.pause) begin
                        ph = P_PAUSE;
                    end else begin
                        if (pos == 5 && laps < LAP_MAX) laps = laps + 1;
                        pos = (pos + 1) % 6;
                        if (!cont) begin
                            rem = rem - 1;
                            if (rem == 0) ph = P_DONE;
                        end
                    end
                end
                P_PAUSE: begin
                    if (bus.abort) begin
                        ph = P_IDLE; abt = 1'b1;
                    end else if (!bus.pause) begin
                        ph = P_RUN;
                    end
                end
                default: ph = P_IDLE;
            endcase
        end
        m_phase <= ph;
        m_pos   <= pos;
        m_laps  <= laps;
        m_rem   <= rem;
        m_cont  <= cont;
        m_abt   <= abt;
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("count",   32'(bus.count),   32'(seq_tab[m_pos]));
            chk("busy",    32'(bus.busy),    32'(m_phase == P_RUN || m_phase == P_PAUSE));
            chk("done",    32'(bus.done),    32'(m_phase == P_DONE));
            chk("aborted", 32'(bus.aborted), 32'(m_abt));
            chk("lap_cnt", 32'(bus.lap_cnt), 32'(m_laps));
            chk("step_en", 32'(bus.step_en), 32'(m_phase == P_RUN && !bus.abort && !bus.pause));
            chk("done_aborted_excl", 32'(bus.done & bus.aborted), 32'(0));
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #2;
    endtask

    task automatic go(input int n, input bit cont);
        bus.start      = 1'b1;
        bus.num_steps  = STEP_W'(n);
        bus.continuous = cont;
        tick(1);
        bus.start      = 1'b0;
        bus.continuous = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.num_steps  = '0;
        bus.continuous = 1'b0;
        bus.pause      = 1'b0;
        bus.abort      = 1'b0;
        tick(2);
        reset  = 1'b0;
        chk_en = 1'b1;

        // Reset state
        chk("rst_count", 32'(bus.count), 32'h0);
        chk("rst_busy",  32'(bus.busy),  32'h0);
        chk("rst_done",  32'(bus.done),  32'h0);
        chk("rst_lap",   32'(bus.lap_cnt), 32'h0);

        // One-shot of 3 steps
        go(3, 1'b0);
        chk("os3_c0", 32'(bus.count), 32'h0);
        chk("os3_busy", 32'(bus.busy), 32'h1);
        tick(1); chk("os3_c1", 32'(bus.count), 32'h1);
        tick(1); chk("os3_c2", 32'(bus.count), 32'h3);
        tick(1); chk("os3_c3", 32'(bus.count), 32'h5);
        chk("os3_done", 32'(bus.done), 32'h1);
        chk("model_pos3", 32'(seq_tab[m_pos]), 32'h5);
        tick(1); chk("os3_hold", 32'(bus.count), 32'h5);
        chk("os3_done_off", 32'(bus.done), 32'h0);

        // One-shot of 6 steps: one full lap
        go(6, 1'b0);
        tick(6);
        chk("os6_count", 32'(bus.count), 32'h0);
        chk("os6_lap", 32'(bus.lap_cnt), 32'h1);
        chk("os6_done", 32'(bus.done), 32'h1);
        tick(1);

        // Zero-length one-shot
        go(0, 1'b0);
        chk("os0_done", 32'(bus.done), 32'h1);
        chk("os0_count", 32'(bus.count), 32'h0);
        chk("os0_step_en", 32'(bus.step_en), 32'h0);
        tick(1);

        // Continuous for 13 advances, then abort
        go(0, 1'b1);
        tick(13);
        chk("cont13_count", 32'(bus.count), 32'h1);
        chk("cont13_lap", 32'(bus.lap_cnt), 32'h2);
        chk("model_laps2", 32'(m_laps), 32'h2);
        bus.abort = 1'b1;
        tick(1);
        bus.abort = 1'b0;
        chk("cont13_aborted", 32'(bus.aborted), 32'h1);
        chk("cont13_nodone", 32'(bus.done), 32'h0);
        chk("cont13_hold", 32'(bus.count), 32'h1);

        // Five steps with a pause after the second
        go(5, 1'b0);
        tick(2);
        bus.pause = 1'b1;
        tick(3);
        chk("pause_hold", 32'(bus.count), 32'h3);
        chk("pause_busy", 32'(bus.busy), 32'h1);
        bus.pause = 1'b0;
        tick(1);
        chk("pause_resume_c", 32'(bus.count), 32'h3);
        tick(3);
        chk("pause_done", 32'(bus.done), 32'h1);
        chk("pause_final", 32'(bus.count), 32'h2);
        tick(1);

        // Start held during a run is ignored
        bus.start = 1'b1; bus.num_steps = STEP_W'(4); bus.continuous = 1'b0;
        tick(3);
        chk("midstart_count", 32'(bus.count), 32'h3);
        bus.start = 1'b0; bus.num_steps = STEP_W'(9);
        tick(2);
        chk("midstart_done", 32'(bus.done), 32'h1);
        chk("midstart_final", 32'(bus.count), 32'h7);
        tick(1);

        // Abort and pause together
        go(0, 1'b1);
        tick(2);
        bus.abort = 1'b1; bus.pause = 1'b1;
        tick(1);
        bus.abort = 1'b0; bus.pause = 1'b0;
        chk("abpa_aborted", 32'(bus.aborted), 32'h1);
        chk("abpa_busy", 32'(bus.busy), 32'h0);
        chk("abpa_count", 32'(bus.count), 32'h3);

        // Abort on the final step
        go(2, 1'b0);
        tick(1);
        bus.abort = 1'b1;
        tick(1);
        bus.abort = 1'b0;
        chk("abfin_aborted", 32'(bus.aborted), 32'h1);
        chk("abfin_nodone", 32'(bus.done), 32'h0);
        chk("abfin_count", 32'(bus.count), 32'h1);
        tick(1);
        chk("abfin_still_nodone", 32'(bus.done), 32'h0);

        // Reset mid-run
        go(0, 1'b1);
        tick(7);
        chk("rstmid_lap_pre", 32'(bus.lap_cnt), 32'h1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("rstmid_count", 32'(bus.count), 32'h0);
        chk("rstmid_busy", 32'(bus.busy), 32'h0);
        chk("rstmid_lap", 32'(bus.lap_cnt), 32'h0);

        // Lap saturation
        go(0, 1'b1);
        tick(6 * 17);
        chk("sat_lap", 32'(bus.lap_cnt), 32'(LAP_MAX));
        chk("sat_count", 32'(bus.count), 32'h0);
        bus.abort = 1'b1;
        tick(1);
        bus.abort = 1'b0;

        // Randomized traffic, checked by the per-cycle compare
        for (int i = 0; i < 600; i++) begin
            reset          = ($urandom_range(0, 99) == 0);
            bus.start      = ($urandom_range(0, 99) < 25);
            bus.num_steps  = STEP_W'($urandom_range(0, 7));
            bus.continuous = ($urandom_range(0, 9) == 0);
            bus.pause      = ($urandom_range(0, 99) < 20);
            bus.abort      = ($urandom_range(0, 99) < 6);
            tick(1);
        end
        reset = 1'b0; bus.start = 1'b0; bus.pause = 1'b0; bus.abort = 1'b0;
        tick(2);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
